fifo_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one SyncFIFO write port between NREQ producers. It accepts valid/ready beats from each producer and drives the FIFO's wEn/dIn, honouring the FIFO's full flag as hard backpressure. Producers can lock the port for multi-beat bursts, bounded by a maximum burst length and an idle timeout. It sits directly in front of the FIFO's write side; the read side is untouched.

---
 rtl/fifo_write_arbiter_pkg.sv | 24 ++
 rtl/fifo_write_arbiter_if.sv | 39 +++
 rtl/fifo_write_arbiter_rr_picker.sv | 34 +++
 rtl/fifo_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// ============================================================================
//  fifo_arb_pkg : shared types and constants for the FIFO write arbiter
//  Rev 1.0
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int STALL_CNT_W = 16;
  localparam int CNT_W       = 4;

  // Index width for NREQ producers, never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_write_arbiter_if.sv
// ============================================================================
//  fifo_write_arbiter_if : producer beats and FIFO write port
//  Rev 1.0
// ============================================================================
`default_nettype none

interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int BITWIDTH = 5
) ();

  localparam int IDW = grant_w(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ*BITWIDTH-1:0] req_data;
  logic [NREQ-1:0]          req_last;
  logic [NREQ-1:0]          req_ready;
  logic                     fifo_full;
  logic                     fifo_wEn;
  logic [BITWIDTH-1:0]      fifo_dIn;
  logic [IDW-1:0]           grant_id;
  logic                     busy;
  logic [STALL_CNT_W-1:0]   stall_cnt;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wEn, fifo_dIn, grant_id, busy, stall_cnt
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wEn, fifo_dIn, grant_id, busy, stall_cnt
  );

endinterface

`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_picker.sv
// ============================================================================
//  rr_picker : first set request at or after start, with wrap-around
//  Rev 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start,
  output logic            found,
  output logic [IDW-1:0]  winner
);

  // With no request the winner falls back to start.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = start;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(start) + k) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
//  fifo_write_arbiter : round-robin arbiter with burst locking onto a FIFO
//  Rev 1.0
// ============================================================================
`default_nettype none

module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int BITWIDTH     = 5,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_write_arbiter_if.slave  bus
);

  localparam int IDW = grant_w(NREQ);
  localparam logic [CNT_W-1:0] c_max_burst    = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] c_idle_timeout = CNT_W'(IDLE_TIMEOUT);

  arb_state_e             state, state_nxt;
  logic [IDW-1:0]         rr_ptr, rr_nxt;
  logic [IDW-1:0]         owner, owner_nxt;
  logic [CNT_W-1:0]       beat_cnt, beat_nxt;
  logic [CNT_W-1:0]       idle_cnt, idle_nxt;
  logic [STALL_CNT_W-1:0] stall_cnt, stall_nxt;

  logic                   found;
  logic [IDW-1:0]         winner;
  logic [IDW-1:0]         sel;
  logic                   owner_valid, owner_last, winner_last;
  logic                   eligible, accept;
  logic [NREQ-1:0]        sel_onehot;
  logic [BITWIDTH-1:0]    sel_data;

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] p);
    return (int'(p) == NREQ - 1) ? '0 : p + IDW'(1);
  endfunction

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req    (bus.req_valid),
    .start  (rr_ptr),
    .found  (found),
    .winner (winner)
  );

  // In ARB with nothing valid, winner equals rr_ptr, so sel is also grant_id.
  assign sel = (state == HOLD) ? owner : winner;

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    winner_last = 1'b0;
    sel_onehot  = '0;
    sel_data    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == owner) begin
        owner_valid = bus.req_valid[i];
        owner_last  = bus.req_last[i];
      end
      if (IDW'(i) == winner) begin
        winner_last = bus.req_last[i];
      end
      if (IDW'(i) == sel) begin
        sel_onehot[i] = 1'b1;
        sel_data      = bus.req_data[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

  assign eligible = (state == HOLD) ? owner_valid : found;
  assign accept   = !rst && eligible && !bus.fifo_full;

  assign bus.req_ready = accept ? sel_onehot : '0;
  assign bus.fifo_wEn  = accept;
  assign bus.fifo_dIn  = rst ? '0 : sel_data;
  assign bus.grant_id  = rst ? '0 : sel;
  assign bus.busy      = (state == HOLD);
  assign bus.stall_cnt = stall_cnt;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    beat_nxt  = beat_cnt;
    idle_nxt  = idle_cnt;
    stall_nxt = stall_cnt;

    if (eligible && bus.fifo_full && stall_cnt != '1) begin
      stall_nxt = stall_cnt + STALL_CNT_W'(1);
    end

    case (state)
      ARB: begin
        if (accept) begin
          if (winner_last || MAX_BURST == 1) begin
            rr_nxt = next_ptr(winner);
          end else begin
            state_nxt = HOLD;
            owner_nxt = winner;
            beat_nxt  = CNT_W'(1);
            idle_nxt  = '0;
          end
        end
      end
      HOLD: begin
        if (owner_valid) begin
          // A full FIFO stalls the owner without counting as idleness.
          if (!bus.fifo_full) begin
            beat_nxt = beat_cnt + CNT_W'(1);
            idle_nxt = '0;
            if (owner_last || (beat_cnt + CNT_W'(1)) == c_max_burst) begin
              state_nxt = ARB;
              rr_nxt    = next_ptr(owner);
            end
          end
        end else begin
          idle_nxt = idle_cnt + CNT_W'(1);
          if ((idle_cnt + CNT_W'(1)) == c_idle_timeout) begin
            state_nxt = ARB;
            rr_nxt    = next_ptr(owner);
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      beat_cnt  <= beat_nxt;
      idle_cnt  <= idle_nxt;
      stall_cnt <= stall_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
//  tb_fifo_write_arbiter : directed table plus random run against a model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_write_arbiter;

  localparam int NREQ = 4;
  localparam int BW   = 5;
  localparam int MB   = 4;
  localparam int IT   = 3;

  logic clk;
  logic rst;

  fifo_write_arbiter_if #(.NREQ(NREQ), .BITWIDTH(BW)) bus ();

  fifo_write_arbiter #(
    .NREQ         (NREQ),
    .BITWIDTH     (BW),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [3:0] ready;
    logic       wen;
    logic [4:0] din;
    logic [1:0] gid;
    logic       busy;
    logic [15:0] stall;
  } vec_t;

  vec_t tbl [24];

  // Reference model: lock status, owner, beats/idle in the current lock.
  int m_locked = 0, m_owner = 0, m_beats = 0, m_idle = 0, m_rr = 0, m_stall = 0;
  int m_sel, m_found, m_elig, m_acc;
  logic [3:0]  e_ready;
  logic        e_wen;
  logic [4:0]  e_din;
  logic [1:0]  e_gid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_eval();
    logic [NREQ*BW-1:0] d;
    d       = bus.req_data;
    m_found = 0;
    m_sel   = m_rr;
    if (m_locked != 0) begin
      m_sel = m_owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (m_found == 0 && bus.req_valid[idx]) begin
          m_found = 1;
          m_sel   = idx;
        end
      end
    end
    m_elig  = (m_locked != 0) ? int'(bus.req_valid[m_owner]) : m_found;
    m_acc   = (!rst && m_elig != 0 && !bus.fifo_full) ? 1 : 0;
    e_ready = (m_acc != 0) ? 4'(1 << m_sel) : 4'd0;
    e_wen   = (m_acc != 0);
    e_din   = rst ? 5'd0 : d[m_sel*BW +: BW];
    e_gid   = rst ? 2'd0 : 2'(m_sel);
  endtask

  task automatic model_update();
    if (rst) begin
      m_locked = 0; m_owner = 0; m_beats = 0; m_idle = 0; m_rr = 0; m_stall = 0;
    end else begin
      if (m_elig != 0 && bus.fifo_full && m_stall < 65535) m_stall++;
      if (m_locked == 0) begin
        if (m_acc != 0) begin
          if (bus.req_last[m_sel] || MB == 1) begin
            m_rr = (m_sel + 1) % NREQ;
          end else begin
            m_locked = 1; m_owner = m_sel; m_beats = 1; m_idle = 0;
          end
        end
      end else if (bus.req_valid[m_owner]) begin
        if (!bus.fifo_full) begin
          m_beats++;
          m_idle = 0;
          if (bus.req_last[m_owner] || m_beats == MB) begin
            m_locked = 0;
            m_rr = (m_owner + 1) % NREQ;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == IT) begin
          m_locked = 0;
          m_rr = (m_owner + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic f, input logic [NREQ*BW-1:0] d);
    @(negedge clk);
    rst           = r;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.fifo_full = f;
    bus.req_data  = d;
    #1;
    model_eval();
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(e_ready));
    chk({tag, ".wen"},   32'(bus.fifo_wEn),  32'(e_wen));
    if (e_wen || rst) chk({tag, ".din"}, 32'(bus.fifo_dIn), 32'(e_din));
    chk({tag, ".gid"},   32'(bus.grant_id),  32'(e_gid));
    chk({tag, ".busy"},  32'(bus.busy),      32'(m_locked));
    chk({tag, ".stall"}, 32'(bus.stall_cnt), 32'(m_stall));
  endtask

  localparam logic [NREQ*BW-1:0] FIXED_DATA = {5'h13, 5'h12, 5'h11, 5'h10};

  initial begin
    //          rst   valid  last   full  ready  wen   din    gid   busy  stall
    tbl[0]  = '{1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 5'h00, 2'd0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 5'h10, 2'd0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h2, 1'b1, 5'h11, 2'd1, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h4, 1'b1, 5'h12, 2'd2, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h8, 1'b1, 5'h13, 2'd3, 1'b0, 16'd0};
    tbl[5]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 5'h10, 2'd0, 1'b0, 16'd0};
    tbl[6]  = '{1'b0, 4'h5, 4'h1, 1'b0, 4'h4, 1'b1, 5'h12, 2'd2, 1'b0, 16'd0};
    tbl[7]  = '{1'b0, 4'h5, 4'h1, 1'b0, 4'h4, 1'b1, 5'h12, 2'd2, 1'b1, 16'd0};
    tbl[8]  = '{1'b0, 4'h5, 4'h1, 1'b0, 4'h4, 1'b1, 5'h12, 2'd2, 1'b1, 16'd0};
    tbl[9]  = '{1'b0, 4'h5, 4'h1, 1'b0, 4'h4, 1'b1, 5'h12, 2'd2, 1'b1, 16'd0};
    tbl[10] = '{1'b0, 4'h5, 4'h1, 1'b0, 4'h1, 1'b1, 5'h10, 2'd0, 1'b0, 16'd0};
    tbl[11] = '{1'b0, 4'hA, 4'h8, 1'b1, 4'h0, 1'b0, 5'h00, 2'd1, 1'b0, 16'd0};
    tbl[12] = '{1'b0, 4'hA, 4'h8, 1'b1, 4'h0, 1'b0, 5'h00, 2'd1, 1'b0, 16'd1};
    tbl[13] = '{1'b0, 4'hA, 4'h8, 1'b1, 4'h0, 1'b0, 5'h00, 2'd1, 1'b0, 16'd2};
    tbl[14] = '{1'b0, 4'hA, 4'h8, 1'b1, 4'h0, 1'b0, 5'h00, 2'd1, 1'b0, 16'd3};
    tbl[15] = '{1'b0, 4'hA, 4'h8, 1'b1, 4'h0, 1'b0, 5'h00, 2'd1, 1'b0, 16'd4};
    tbl[16] = '{1'b0, 4'hA, 4'h8, 1'b0, 4'h2, 1'b1, 5'h11, 2'd1, 1'b0, 16'd5};
    tbl[17] = '{1'b0, 4'h8, 4'h8, 1'b0, 4'h0, 1'b0, 5'h00, 2'd1, 1'b1, 16'd5};
    tbl[18] = '{1'b0, 4'h8, 4'h8, 1'b0, 4'h0, 1'b0, 5'h00, 2'd1, 1'b1, 16'd5};
    tbl[19] = '{1'b0, 4'h8, 4'h8, 1'b0, 4'h0, 1'b0, 5'h00, 2'd1, 1'b1, 16'd5};
    tbl[20] = '{1'b0, 4'hC, 4'hC, 1'b0, 4'h4, 1'b1, 5'h12, 2'd2, 1'b0, 16'd5};
    tbl[21] = '{1'b0, 4'h4, 4'h0, 1'b0, 4'h4, 1'b1, 5'h12, 2'd2, 1'b0, 16'd5};
    tbl[22] = '{1'b1, 4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 5'h00, 2'd0, 1'b1, 16'd5};
    tbl[23] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 5'h00, 2'd0, 1'b0, 16'd0};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    repeat (2) begin
      drive(1'b1, 4'h0, 4'h0, 1'b0, FIXED_DATA);
      model_update();
    end

    // Directed table: round-robin, burst cap, full stall, idle timeout, reset mid-burst.
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].last, tbl[i].full, FIXED_DATA);
      chk($sformatf("tbl%0d.ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d.wen", i),   32'(bus.fifo_wEn),  32'(tbl[i].wen));
      if (tbl[i].wen || tbl[i].rst)
        chk($sformatf("tbl%0d.din", i), 32'(bus.fifo_dIn),  32'(tbl[i].din));
      chk($sformatf("tbl%0d.gid", i),   32'(bus.grant_id),  32'(tbl[i].gid));
      chk($sformatf("tbl%0d.busy", i),  32'(bus.busy),      32'(tbl[i].busy));
      chk($sformatf("tbl%0d.stall", i), 32'(bus.stall_cnt), 32'(tbl[i].stall));
      model_update();
    end

    // Random traffic against the model.
    drive(1'b1, 4'h0, 4'h0, 1'b0, FIXED_DATA);
    model_update();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] v, l;
      logic f, r;
      v = 4'($urandom_range(0, 15));
      l = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      f = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 199) == 0);
      drive(r, v, l, f, 20'($urandom));
      check_model($sformatf("rnd%0d", n));
      model_update();
    end

    // Saturation of the stall counter under a long full period.
    drive(1'b1, 4'h0, 4'h0, 1'b0, FIXED_DATA);
    model_update();
    for (int n = 0; n < 65534; n++) begin
      drive(1'b0, 4'h2, 4'h2, 1'b1, FIXED_DATA);
      model_update();
    end
    drive(1'b0, 4'h2, 4'h2, 1'b1, FIXED_DATA);
    chk("sat.fffe", 32'(bus.stall_cnt), 32'h0000FFFE);
    chk("sat.wen", 32'(bus.fifo_wEn), 32'h0);
    model_update();
    for (int n = 0; n < 6; n++) begin
      drive(1'b0, 4'h2, 4'h2, 1'b1, FIXED_DATA);
      model_update();
    end
    chk("sat.ffff", 32'(bus.stall_cnt), 32'h0000FFFF);
    drive(1'b0, 4'h2, 4'h2, 1'b0, FIXED_DATA);
    chk("sat.hold", 32'(bus.stall_cnt), 32'h0000FFFF);
    chk("sat.grant", 32'(bus.req_ready), 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
